// File: rtl/trax_pkg.sv
// Shared Trax definitions: tile codes, move-word layout and turn-sequencer states.
package trax_pkg;

  localparam int MOVE_W = 22;

  localparam logic [1:0] TILE_PLUS   = 2'b01;
  localparam logic [1:0] TILE_SLASH  = 2'b10;
  localparam logic [1:0] TILE_BSLASH = 2'b11;

  localparam int TILE_HI = 21;
  localparam int TILE_LO = 20;
  localparam int COL_HI  = 19;
  localparam int COL_LO  = 10;
  localparam int ROW_HI  = 9;
  localparam int ROW_LO  = 0;

  localparam int ROUND_W = 10;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_OPP_APPLY  = 4'd1,
    S_OPP_AC     = 4'd2,
    S_OPP_COMMIT = 4'd3,
    S_CHOOSE     = 4'd4,
    S_OWN_APPLY  = 4'd5,
    S_OWN_AC     = 4'd6,
    S_OWN_COMMIT = 4'd7,
    S_SEND       = 4'd8,
    S_DEAD       = 4'd9
  } seq_state_e;

endpackage

// File: rtl/trax_seq_watchdog.sv
// Engine-wait watchdog: counts cycles spent waiting for a done and flags the limit.
module trax_seq_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  output logic timeout_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive wait cycle.
  assign timeout_o = run_i && (cnt_q == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/trax_turn_sequencer.sv
// Turn-level controller driving the Trax board engines through start/done handshakes.
// Optional engine-wait watchdog enabled by defining TRAX_SEQ_TIMEOUT_EN.
module trax_turn_sequencer
  import trax_pkg::*;
#(
  parameter int MOVE_W        = trax_pkg::MOVE_W,
  parameter int MAX_AC_PASSES = 16,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [MOVE_W-1:0] rx_move,
  input  logic              color,
  output logic              apply_start,
  output logic [MOVE_W-1:0] apply_move,
  input  logic              apply_done,
  output logic              ac_start,
  input  logic              ac_done,
  input  logic              ac_changed,
  output logic              commit_start,
  input  logic              commit_done,
  output logic              choose_start,
  input  logic              choose_done,
  input  logic [7:0]        choose_cnt,
  input  logic [MOVE_W-1:0] choose_move,
  output logic              tx_start,
  output logic [MOVE_W-1:0] tx_move,
  output logic              busy,
  output logic [9:0]        round,
  output logic [1:0]        err
);

  localparam int PASS_W = $clog2(MAX_AC_PASSES + 1);
  localparam logic [MOVE_W-1:0] OPENER = {TILE_PLUS, {(MOVE_W-2){1'b0}}};

  seq_state_e          state_q, state_d;
  logic                entry_q, entry_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic [1:0]          err_q, err_d;
  logic [MOVE_W-1:0]   apply_move_q, apply_move_d;
  logic [MOVE_W-1:0]   tx_move_q, tx_move_d;
  logic                engine_st, wait_st;

  function automatic logic [ROUND_W-1:0] sat_inc_round(input logic [ROUND_W-1:0] v);
    return (v == {ROUND_W{1'b1}}) ? v : v + ROUND_W'(1);
  endfunction

  assign engine_st = (state_q == S_OPP_APPLY) || (state_q == S_OWN_APPLY) ||
                     (state_q == S_OPP_AC)    || (state_q == S_OWN_AC)    ||
                     (state_q == S_OPP_COMMIT)|| (state_q == S_OWN_COMMIT)||
                     (state_q == S_CHOOSE);
  // The entry cycle carries the start pulse; done is only honoured afterwards.
  assign wait_st   = engine_st && !entry_q;

`ifdef TRAX_SEQ_TIMEOUT_EN
  logic timeout;

  trax_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (engine_st && entry_q),
    .run_i     (wait_st),
    .timeout_o (timeout)
  );
`endif

  always_comb begin
    state_d      = state_q;
    entry_d      = 1'b0;
    pass_d       = pass_q;
    round_d      = round_q;
    err_d        = err_q;
    apply_move_d = apply_move_q;
    tx_move_d    = tx_move_q;

    if (rx_valid && (state_q != S_IDLE)) begin
      err_d[0] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          entry_d = 1'b1;
          if ((round_q == '0) && !color) begin
            apply_move_d = OPENER;
            tx_move_d    = OPENER;
            state_d      = S_OWN_APPLY;
          end else begin
            apply_move_d = rx_move;
            state_d      = S_OPP_APPLY;
          end
        end
      end
      S_OPP_APPLY, S_OWN_APPLY: begin
        if (!entry_q && apply_done) begin
          entry_d = 1'b1;
          pass_d  = '0;
          state_d = (state_q == S_OPP_APPLY) ? S_OPP_AC : S_OWN_AC;
        end
      end
      S_OPP_AC, S_OWN_AC: begin
        if (!entry_q && ac_done) begin
          if (ac_changed) begin
            if (pass_q == PASS_W'(MAX_AC_PASSES - 1)) begin
              state_d  = S_DEAD;
              err_d[1] = 1'b1;
            end else begin
              pass_d  = pass_q + PASS_W'(1);
              entry_d = 1'b1;
            end
          end else begin
            entry_d = 1'b1;
            state_d = (state_q == S_OPP_AC) ? S_OPP_COMMIT : S_OWN_COMMIT;
          end
        end
      end
      S_OPP_COMMIT, S_OWN_COMMIT: begin
        if (!entry_q && commit_done) begin
          entry_d = 1'b1;
          state_d = (state_q == S_OPP_COMMIT) ? S_CHOOSE : S_SEND;
        end
      end
      S_CHOOSE: begin
        if (!entry_q && choose_done) begin
          if (choose_cnt == 8'd0) begin
            state_d  = S_DEAD;
            err_d[1] = 1'b1;
          end else begin
            apply_move_d = choose_move;
            tx_move_d    = choose_move;
            entry_d      = 1'b1;
            state_d      = S_OWN_APPLY;
          end
        end
      end
      S_SEND: begin
        round_d = sat_inc_round(round_q);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_DEAD;
      end
    endcase

`ifdef TRAX_SEQ_TIMEOUT_EN
    if (timeout) begin
      state_d  = S_DEAD;
      entry_d  = 1'b0;
      err_d[1] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      entry_q      <= 1'b0;
      pass_q       <= '0;
      round_q      <= '0;
      err_q        <= '0;
      apply_move_q <= '0;
      tx_move_q    <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      pass_q       <= pass_d;
      round_q      <= round_d;
      err_q        <= err_d;
      apply_move_q <= apply_move_d;
      tx_move_q    <= tx_move_d;
    end
  end

  assign apply_start  = entry_q && ((state_q == S_OPP_APPLY)  || (state_q == S_OWN_APPLY));
  assign ac_start     = entry_q && ((state_q == S_OPP_AC)     || (state_q == S_OWN_AC));
  assign commit_start = entry_q && ((state_q == S_OPP_COMMIT) || (state_q == S_OWN_COMMIT));
  assign choose_start = entry_q && (state_q == S_CHOOSE);
  assign tx_start     = (state_q == S_SEND);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DEAD);
  assign apply_move   = apply_move_q;
  assign tx_move      = tx_move_q;
  assign round        = round_q;
  assign err          = err_q;

endmodule

// File: tb/tb_trax_turn_sequencer.sv
// Randomized self-checking bench for trax_turn_sequencer against a turn-level reference model.
module tb_trax_turn_sequencer;

  localparam int MW  = 22;
  localparam int MAX = 16;

  logic          clk, reset, rx_valid, color;
  logic [MW-1:0] rx_move, apply_move, choose_move, tx_move;
  logic          apply_start, apply_done, ac_start, ac_done, ac_changed;
  logic          commit_start, commit_done, choose_start, choose_done, tx_start, busy;
  logic [7:0]    choose_cnt;
  logic [9:0]    round;
  logic [1:0]    err;

  trax_turn_sequencer #(.MOVE_W(MW), .MAX_AC_PASSES(MAX), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_move(rx_move), .color(color),
    .apply_start(apply_start), .apply_move(apply_move), .apply_done(apply_done),
    .ac_start(ac_start), .ac_done(ac_done), .ac_changed(ac_changed),
    .commit_start(commit_start), .commit_done(commit_done),
    .choose_start(choose_start), .choose_done(choose_done),
    .choose_cnt(choose_cnt), .choose_move(choose_move),
    .tx_start(tx_start), .tx_move(tx_move), .busy(busy), .round(round), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine stand-ins and pulse monitor
  int          n_apply = 0, n_ac = 0, n_commit = 0, n_choose = 0, n_tx = 0;
  logic [MW-1:0] apply_log[$];
  int          ac_plan[$];
  int          ac_left = 0;
  bit          hold_commit = 0;
  logic [7:0]  cfg_cnt = 8'd1;
  logic [MW-1:0] cfg_move = '0;
  bit          p_apply = 0, p_ac = 0, p_commit = 0, p_choose = 0;

  initial begin
    apply_done = 0; ac_done = 0; ac_changed = 0; commit_done = 0;
    choose_done = 0; choose_cnt = 0; choose_move = '0;
    forever begin
      @(posedge clk);
      #1;
      apply_done  = p_apply;
      ac_done     = p_ac;
      commit_done = p_commit && !hold_commit;
      choose_done = p_choose;
      ac_changed  = 1'b0;
      if (p_ac) begin
        ac_changed = (ac_left > 0);
        if (ac_left > 0) ac_left--;
      end
      choose_cnt  = p_choose ? cfg_cnt  : 8'd0;
      choose_move = p_choose ? cfg_move : '0;
      p_apply = apply_start; p_ac = ac_start; p_commit = commit_start; p_choose = choose_start;
      if (apply_start) begin
        n_apply++;
        apply_log.push_back(apply_move);
        ac_left = (ac_plan.size() > 0) ? ac_plan.pop_front() : 0;
      end
      if (ac_start)     n_ac++;
      if (commit_start) n_commit++;
      if (choose_start) n_choose++;
      if (tx_start)     n_tx++;
    end
  end

  // Reference model state
  int            m_round = 0;
  logic [1:0]    m_err   = 2'b00;
  logic [MW-1:0] m_tx    = '0;

  function automatic logic [63:0] all_outs();
    return 64'({apply_start, ac_start, commit_start, choose_start, tx_start, busy,
                err, round, apply_move, tx_move});
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val(tag, all_outs(), 64'd0);
    reset = 1'b0;
    m_round = 0; m_err = 2'b00; m_tx = '0;
  endtask

  task automatic run_turn(input logic [MW-1:0] rmv, input int o_opp, input int o_own,
                          input int cnt, input logic [MW-1:0] cmv, input bit ovr);
    int a0, c0, m0, h0, t0;
    int e_apply, e_ac, e_commit, e_choose, e_tx;
    bit opener, dead, done, inj;
    logic [MW-1:0] e_own;
    logic [MW-1:0] e_log[$];
    opener = (m_round == 0) && (color == 1'b0);
    e_apply = 0; e_ac = 0; e_commit = 0; e_choose = 0; e_tx = 0; dead = 0;
    if (opener) begin
      e_own = {2'b01, 10'd0, 10'd0};
      m_tx  = e_own;
    end else begin
      e_own = cmv;
      e_apply = 1; e_log.push_back(rmv);
      if (o_opp >= MAX) begin e_ac = MAX; dead = 1; end
      else begin
        e_ac = o_opp + 1; e_commit = 1; e_choose = 1;
        if (cnt == 0) dead = 1; else m_tx = cmv;
      end
    end
    if (!dead) begin
      e_apply++; e_log.push_back(e_own);
      if (o_own >= MAX) begin e_ac += MAX; dead = 1; end
      else begin e_ac += o_own + 1; e_commit++; e_tx = 1; end
    end
    if (e_tx == 1 && m_round < 1023) m_round++;
    if (dead) m_err[1] = 1'b1;
    if (ovr)  m_err[0] = 1'b1;

    cfg_cnt = 8'(cnt); cfg_move = cmv;
    ac_plan.delete();
    if (!opener) ac_plan.push_back(o_opp);
    ac_plan.push_back(o_own);
    apply_log.delete();
    a0 = n_apply; c0 = n_ac; m0 = n_commit; h0 = n_choose; t0 = n_tx;
    @(negedge clk);
    rx_valid = 1'b1; rx_move = rmv;
    @(negedge clk);
    rx_valid = 1'b0;
    done = 0; inj = 0;
    for (int i = 0; i < 600; i++) begin
      if (n_tx != t0 || err[1]) begin done = 1; break; end
      if (ovr && !inj && n_ac != c0) begin rx_valid = 1'b1; inj = 1; end
      @(negedge clk);
      rx_valid = 1'b0;
    end
    check_val("turn_done", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    check_val("apply_cnt",  64'(n_apply - a0),  64'(e_apply));
    check_val("ac_cnt",     64'(n_ac - c0),     64'(e_ac));
    check_val("commit_cnt", 64'(n_commit - m0), 64'(e_commit));
    check_val("choose_cnt", 64'(n_choose - h0), 64'(e_choose));
    check_val("tx_cnt",     64'(n_tx - t0),     64'(e_tx));
    check_val("tx_move",    64'(tx_move),       64'(m_tx));
    check_val("round",      64'(round),         64'(m_round));
    check_val("err",        64'(err),           64'(m_err));
    check_val("busy",       64'(busy),          64'd0);
    check_val("apply_log_n", 64'(apply_log.size()), 64'(e_log.size()));
    for (int k = 0; k < e_log.size() && k < apply_log.size(); k++)
      check_val("apply_move", 64'(apply_log[k]), 64'(e_log[k]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0, c0;
    bit seen;
    logic [MW-1:0] mv;
    reset = 1'b1; rx_valid = 1'b0; rx_move = '0; color = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("reset_outs");

    // White opener, then a normal turn
    color = 1'b0;
    run_turn(22'h3FFFFF, 0, 0, 1, 22'h0, 0);
    run_turn(22'h100400, 0, 0, 3, 22'h200401, 0);

    // AC repeats on the opponent half, and an overrun during OPP_AC
    run_turn(22'h100801, 3, 0, 5, 22'h300C02, 0);
    run_turn(22'h200C03, 1, 2, 7, 22'h101004, 1);
    do_reset("reset_clr_err");

    // AC never settles: abort after MAX passes
    color = 1'b1;
    run_turn(22'h100000, 100, 0, 1, 22'h0, 0);
    repeat (20) @(negedge clk);
    check_val("dead_quiet_busy", 64'(busy), 64'd0);
    do_reset("reset_after_ac");

    // No legal move
    run_turn(22'h200401, 0, 0, 0, 22'h111111, 0);
    t0 = n_tx;
    repeat (20) @(negedge clk);
    check_val("dead_no_tx", 64'(n_tx - t0), 64'd0);
    do_reset("reset_after_nomove");

    // Reset while in CHOOSE
    cfg_cnt = 8'd2; cfg_move = 22'h123456;
    ac_plan.delete(); ac_plan.push_back(0);
    c0 = n_choose; seen = 0;
    @(negedge clk); rx_valid = 1'b1; rx_move = 22'h100401;
    @(negedge clk); rx_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_choose != c0) begin seen = 1; break; end
      @(negedge clk);
    end
    check_val("reach_choose", 64'(seen), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_in_choose", all_outs(), 64'd0);
    reset = 1'b0;
    m_round = 0; m_err = 2'b00; m_tx = '0;
    c0 = n_apply + n_ac + n_commit + n_choose + n_tx;
    repeat (6) @(negedge clk);
    check_val("post_reset_quiet", 64'(n_apply + n_ac + n_commit + n_choose + n_tx), 64'(c0));
    check_val("post_reset_busy", 64'(busy), 64'd0);

    // Commit never answers
    hold_commit = 1;
    ac_plan.delete(); ac_plan.push_back(0);
    c0 = n_commit; seen = 0;
    @(negedge clk); rx_valid = 1'b1; rx_move = 22'h100401;
    @(negedge clk); rx_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_commit != c0) begin seen = 1; break; end
      @(negedge clk);
    end
    check_val("reach_commit", 64'(seen), 64'd1);
`ifdef TRAX_SEQ_TIMEOUT_EN
    repeat (7) @(negedge clk);
    check_val("wdog_still_busy", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    check_val("wdog_dead_busy", 64'(busy), 64'd0);
    check_val("wdog_err", 64'(err), 64'd2);
`else
    repeat (100) @(negedge clk);
    check_val("wait_busy", 64'(busy), 64'd1);
    check_val("wait_err", 64'(err), 64'd0);
`endif
    hold_commit = 0;
    do_reset("reset_after_wait");

    // Randomized turns
    for (int n = 0; n < 60; n++) begin
      int oo, ow, cn;
      color = 1'($urandom_range(0, 1));
      oo = ($urandom_range(0, 19) == 0) ? MAX + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      ow = ($urandom_range(0, 19) == 0) ? MAX + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      cn = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 255));
      mv = MW'($urandom);
      run_turn(MW'($urandom), oo, ow, cn, mv, ($urandom_range(0, 9) == 0));
      if (m_err[1]) do_reset("reset_rnd");
    end

    // Round counter saturation
    do_reset("reset_sat");
    color = 1'b1;
    for (int n = 0; n < 1026; n++) begin
      mv = MW'($urandom);
      run_turn(MW'($urandom), 0, 0, 1, mv, 0);
    end
    check_val("round_sat", 64'(round), 64'd1023);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
